dca_matrix_step_dispatcher: RTL and testbench



---
 rtl/dca_matrix_step_dispatcher_pkg.sv | 22 ++
 rtl/dca_step_fifo.sv | 59 +++++
 rtl/dca_matrix_step_dispatcher.sv | 152 +++++++++++++++
 tb/tb_dca_matrix_step_dispatcher.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dca_matrix_step_dispatcher_pkg.sv
// Shared constants for the MAC step dispatcher: opcode bit positions, FSM encoding, counter width.
// Optional perf counters in the top are enabled with DCA_STEP_DISPATCH_PERF_EN.
package dca_matrix_step_dispatcher_pkg;

    localparam int LSU0_REQ  = 0;
    localparam int LSU1_REQ  = 1;
    localparam int LSU2_REQ  = 2;
    localparam int LOAD_ACC  = 3;
    localparam int INIT_ACC  = 4;
    // Last-element flag sits just above the default 8-bit opcode field.
    localparam int LAST_ELEM = 8;

    localparam int PERF_W    = 32;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_RUN          = 2'd1,
        ST_STALL        = 2'd2,
        ST_BACKPRESSURE = 2'd3
    } disp_state_t;

endpackage

// File: rtl/dca_step_fifo.sv
// Parametric synchronous FIFO with flush; head word is visible combinationally on o_data.
module dca_step_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [W-1:0]             i_data,
    output logic [W-1:0]             o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; entries are only read once counted valid.
    always_ff @(posedge i_clk) begin
        if (w_push & ~i_clear) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/dca_matrix_step_dispatcher.sv
// Buffers blocked-step instructions, waits for LSU operands, dispatches to the PE array.
// Define DCA_STEP_DISPATCH_PERF_EN to add saturating stall/backpressure cycle counters.
//
//  state           | meaning
//  ST_IDLE         | FIFO empty and no step presented
//  ST_RUN          | a step was dispatched in the last enabled cycle
//  ST_STALL        | head present but its operands are not all available
//  ST_BACKPRESSURE | step presented, PE array not ready, FIFO non-empty
module dca_matrix_step_dispatcher
    import dca_matrix_step_dispatcher_pkg::*;
#(
    parameter int INST_WIDTH   = 64,
    parameter int OPCODE_WIDTH = 8,
    parameter int DEPTH        = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_clear,
    input  logic                    i_enable,
    input  logic                    i_step_valid,
    output logic                    o_step_ready,
    input  logic [INST_WIDTH-1:0]   i_step_inst,
    input  logic                    i_lsu0_avail,
    input  logic                    i_lsu1_avail,
    input  logic                    i_lsu2_avail,
    output logic                    o_lsu0_consume,
    output logic                    o_lsu1_consume,
    output logic                    o_lsu2_consume,
    output logic                    o_pe_valid,
    input  logic                    i_pe_ready,
    output logic [INST_WIDTH-1:0]   o_pe_inst,
    output logic                    o_inst_done,
    output logic [$clog2(DEPTH):0]  o_occupancy,
    output logic                    o_busy
`ifdef DCA_STEP_DISPATCH_PERF_EN
    ,
    input  logic                    i_perf_clear,
    output logic [PERF_W-1:0]       o_perf_stall_cycles,
    output logic [PERF_W-1:0]       o_perf_bp_cycles
`endif
);
    localparam int LAST_POS = (LAST_ELEM >= OPCODE_WIDTH) ? LAST_ELEM : OPCODE_WIDTH;

    logic [INST_WIDTH-1:0] w_head;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_req0, w_req1, w_req2;
    logic                  w_head_ok;
    logic                  w_out_free;
    logic                  w_advance;
    logic                  w_dispatch;

    logic                  r_pe_valid;
    logic [INST_WIDTH-1:0] r_pe_inst;
    disp_state_t           r_state;

    assign o_step_ready = i_enable & ~w_full & ~i_clear;
    assign w_push       = i_step_valid & o_step_ready;

    // LSU2_REQ alone is a write and needs no input operand.
    assign w_req0     = w_head[LSU0_REQ];
    assign w_req1     = w_head[LSU1_REQ];
    assign w_req2     = w_head[LOAD_ACC];
    assign w_head_ok  = ~w_empty & (~w_req0 | i_lsu0_avail)
                                 & (~w_req1 | i_lsu1_avail)
                                 & (~w_req2 | i_lsu2_avail);
    assign w_out_free = ~r_pe_valid | i_pe_ready;
    assign w_advance  = i_enable & ~i_clear;
    assign w_dispatch = w_advance & w_head_ok & w_out_free;

    dca_step_fifo #(
        .W     (INST_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (i_clear),
        .i_push  (w_push),
        .i_pop   (w_dispatch),
        .i_data  (i_step_inst),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (o_occupancy)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pe_valid <= 1'b0;
            r_pe_inst  <= '0;
        end else if (i_clear) begin
            r_pe_valid <= 1'b0;
        end else if (i_enable) begin
            if (w_dispatch) begin
                r_pe_valid <= 1'b1;
                r_pe_inst  <= w_head;
            end else if (i_pe_ready) begin
                r_pe_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else if (i_clear) begin
            r_state <= ST_IDLE;
        end else if (i_enable) begin
            if (w_dispatch)
                r_state <= ST_RUN;
            else if (r_pe_valid & ~i_pe_ready & ~w_empty)
                r_state <= ST_BACKPRESSURE;
            else if (~w_empty & ~w_head_ok)
                r_state <= ST_STALL;
            else
                r_state <= ST_IDLE;
        end
    end

    assign o_lsu0_consume = w_dispatch & w_req0;
    assign o_lsu1_consume = w_dispatch & w_req1;
    assign o_lsu2_consume = w_dispatch & w_req2;
    assign o_pe_valid     = r_pe_valid;
    assign o_pe_inst      = r_pe_inst;
    assign o_inst_done    = w_advance & r_pe_valid & i_pe_ready & r_pe_inst[LAST_POS];
    assign o_busy         = ~w_empty | r_pe_valid;

`ifdef DCA_STEP_DISPATCH_PERF_EN
    logic [PERF_W-1:0] r_perf_stall;
    logic [PERF_W-1:0] r_perf_bp;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_perf_stall <= '0;
            r_perf_bp    <= '0;
        end else if (i_perf_clear) begin
            r_perf_stall <= '0;
            r_perf_bp    <= '0;
        end else if (i_enable) begin
            if (r_state == ST_STALL && ~&r_perf_stall)
                r_perf_stall <= r_perf_stall + 1'b1;
            if (r_state == ST_BACKPRESSURE && ~&r_perf_bp)
                r_perf_bp <= r_perf_bp + 1'b1;
        end
    end

    assign o_perf_stall_cycles = r_perf_stall;
    assign o_perf_bp_cycles    = r_perf_bp;
`endif

endmodule

// File: tb/tb_dca_matrix_step_dispatcher.sv
// Self-checking bench for dca_matrix_step_dispatcher: directed scenarios plus a random phase
// checked each cycle against a queue-based model of the dispatcher.
module tb_dca_matrix_step_dispatcher;
    import dca_matrix_step_dispatcher_pkg::*;

    localparam int W = 64;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst, clr, en, sv, a0, a1, a2, pr;
    logic [W-1:0] si;
    logic         o_step_ready, o_c0, o_c1, o_c2, o_pe_valid, o_inst_done, o_busy;
    logic [W-1:0] o_pe_inst;
    logic [2:0]   o_occupancy;
`ifdef DCA_STEP_DISPATCH_PERF_EN
    logic [31:0]  o_perf_stall, o_perf_bp;
`endif

    always #5 clk = ~clk;

    dca_matrix_step_dispatcher #(.INST_WIDTH(W), .OPCODE_WIDTH(8), .DEPTH(D)) dut (
        .i_clk(clk), .i_rst(rst), .i_clear(clr), .i_enable(en),
        .i_step_valid(sv), .o_step_ready(o_step_ready), .i_step_inst(si),
        .i_lsu0_avail(a0), .i_lsu1_avail(a1), .i_lsu2_avail(a2),
        .o_lsu0_consume(o_c0), .o_lsu1_consume(o_c1), .o_lsu2_consume(o_c2),
        .o_pe_valid(o_pe_valid), .i_pe_ready(pr), .o_pe_inst(o_pe_inst),
        .o_inst_done(o_inst_done), .o_occupancy(o_occupancy), .o_busy(o_busy)
`ifdef DCA_STEP_DISPATCH_PERF_EN
        , .i_perf_clear(1'b0), .o_perf_stall_cycles(o_perf_stall), .o_perf_bp_cycles(o_perf_bp)
`endif
    );

    int vecs = 0;
    int errs = 0;

    // Reference model: queue of buffered steps plus the single presented step.
    logic [W-1:0] mq[$];
    logic         m_pv;
    logic [W-1:0] m_pi;

    int           n_c0, n_c1, n_c2, n_done, max_occ;
    logic         s_ready;
    logic [W-1:0] got[$];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic [7:0] op, input logic last);
        logic [W-1:0] r;
        r = {$urandom, $urandom};
        r[7:0] = op;
        r[LAST_ELEM] = last;
        return r;
    endfunction

    task automatic clr_tally();
        n_c0 = 0; n_c1 = 0; n_c2 = 0; n_done = 0; max_occ = 0;
        got.delete();
    endtask

    task automatic model_reset();
        mq.delete();
        m_pv = 1'b0;
        m_pi = '0;
    endtask

    // One clock: compare outputs at the falling edge, advance the model, return 1ns after the rising edge.
    task automatic tick();
        logic [W-1:0] h;
        logic full, ready, hok, free, disp;
        @(negedge clk);
        h     = (mq.size() != 0) ? mq[0] : '0;
        full  = (mq.size() == D);
        ready = en & ~full & ~clr;
        hok   = (mq.size() != 0) && (!h[LSU0_REQ] || a0) && (!h[LSU1_REQ] || a1) && (!h[LOAD_ACC] || a2);
        free  = !m_pv || pr;
        disp  = en & ~clr & hok & free;

        chk("step_ready", W'(o_step_ready), W'(ready));
        chk("lsu0_consume", W'(o_c0), W'(disp & h[LSU0_REQ]));
        chk("lsu1_consume", W'(o_c1), W'(disp & h[LSU1_REQ]));
        chk("lsu2_consume", W'(o_c2), W'(disp & h[LOAD_ACC]));
        chk("inst_done", W'(o_inst_done), W'(en & ~clr & m_pv & pr & m_pi[LAST_ELEM]));
        chk("pe_valid", W'(o_pe_valid), W'(m_pv));
        if (m_pv) chk("pe_inst", o_pe_inst, m_pi);
        chk("occupancy", W'(o_occupancy), W'(mq.size()));
        chk("busy", W'(o_busy), W'((mq.size() != 0) || m_pv));

        n_c0 += int'(o_c0);
        n_c1 += int'(o_c1);
        n_c2 += int'(o_c2);
        n_done += int'(o_inst_done);
        if (int'(o_occupancy) > max_occ) max_occ = int'(o_occupancy);
        if (o_pe_valid && pr && en && !clr) got.push_back(o_pe_inst);
        s_ready = o_step_ready;

        if (clr) begin
            mq.delete();
            m_pv = 1'b0;
        end else if (en) begin
            if (disp) begin
                m_pi = mq.pop_front();
                m_pv = 1'b1;
            end else if (pr) begin
                m_pv = 1'b0;
            end
            if (sv && ready) mq.push_back(si);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] list[6];
        int idx, cyc;
        logic saw_full;

        rst = 1'b1; clr = 1'b0; en = 1'b1; sv = 1'b0; si = '0;
        a0 = 1'b0; a1 = 1'b0; a2 = 1'b0; pr = 1'b0;
        model_reset();
        #12;
        chk("rst_step_ready", W'(o_step_ready), W'(1));
        chk("rst_pe_valid", W'(o_pe_valid), W'(0));
        chk("rst_pe_inst", o_pe_inst, '0);
        chk("rst_occupancy", W'(o_occupancy), W'(0));
        chk("rst_busy", W'(o_busy), W'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Single LSU0|LSU1 step: presented two cycles after the push, one pulse per operand.
        clr_tally();
        a0 = 1'b1; a1 = 1'b1; a2 = 1'b1; pr = 1'b1;
        sv = 1'b1; si = mk(8'h03, 1'b0);
        tick();
        sv = 1'b0;
        chk("lat_n1_pe_valid", W'(o_pe_valid), W'(0));
        tick();
        chk("lat_n2_pe_valid", W'(o_pe_valid), W'(1));
        repeat (3) tick();
        chk("single_c0_pulses", W'(n_c0), W'(1));
        chk("single_c1_pulses", W'(n_c1), W'(1));
        chk("single_c2_pulses", W'(n_c2), W'(0));

        // LOAD_ACC step held while LSU2 data is missing.
        clr_tally();
        a2 = 1'b0;
        sv = 1'b1; si = mk(8'h08, 1'b0);
        tick();
        sv = 1'b0;
        repeat (5) tick();
        chk("stall_no_dispatch", W'(o_pe_valid), W'(0));
        chk("stall_no_pulse", W'(n_c2), W'(0));
        chk("stall_occupancy", W'(o_occupancy), W'(1));
        a2 = 1'b1;
        tick();
        chk("stall_release_c2", W'(n_c2), W'(1));
        a2 = 1'b0;
        repeat (3) tick();
        a2 = 1'b1;

        // Back-to-back pushes against a blocked PE array: FIFO fills, order preserved.
        clr_tally();
        for (int i = 0; i < 6; i++) list[i] = mk(8'(i), 1'b0);
        idx = 0; cyc = 0; saw_full = 1'b0;
        while (idx < 6 && cyc < 60) begin
            pr = (cyc >= 10);
            sv = 1'b1;
            si = list[idx];
            tick();
            if (s_ready) idx++;
            else saw_full = 1'b1;
            cyc++;
        end
        sv = 1'b0; pr = 1'b1;
        repeat (8) tick();
        chk("order_all_accepted", W'(idx), W'(6));
        chk("order_saw_full", W'(saw_full), W'(1));
        chk("order_count", W'(got.size()), W'(6));
        for (int i = 0; i < 6; i++)
            if (i < got.size()) chk($sformatf("order_inst%0d", i), got[i], list[i]);

        // Streaming: one step per cycle, two steps flagged last.
        clr_tally();
        for (int i = 0; i < 16; i++) begin
            sv = 1'b1;
            si = mk(8'($urandom_range(0, 31)), (i == 5) || (i == 12));
            tick();
        end
        sv = 1'b0;
        repeat (4) tick();
        chk("stream_throughput", W'(got.size()), W'(16));
        chk("stream_occ_le2", W'(max_occ <= 2), W'(1));
        chk("stream_done_pulses", W'(n_done), W'(2));

        // Flush with three queued entries and one step presented.
        pr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sv = 1'b1;
            si = mk(8'h03, 1'b1);
            tick();
        end
        sv = 1'b0;
        chk("pre_clear_occ", W'(o_occupancy), W'(3));
        chk("pre_clear_pv", W'(o_pe_valid), W'(1));
        clr_tally();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clear_occ", W'(o_occupancy), W'(0));
        chk("clear_pv", W'(o_pe_valid), W'(0));
        chk("clear_busy", W'(o_busy), W'(0));
        chk("clear_no_pulse", W'(n_c0 + n_c1 + n_c2 + n_done), W'(0));
        pr = 1'b1;
        tick();

        // Asynchronous reset while a step is held by backpressure.
        pr = 1'b0;
        sv = 1'b1; si = mk(8'h01, 1'b0);
        tick();
        sv = 1'b0;
        tick();
        chk("prerst_pv", W'(o_pe_valid), W'(1));
        rst = 1'b1;
        #2;
        chk("arst_pe_valid", W'(o_pe_valid), W'(0));
        chk("arst_pe_inst", o_pe_inst, '0);
        chk("arst_step_ready", W'(o_step_ready), W'(1));
        chk("arst_occupancy", W'(o_occupancy), W'(0));
        chk("arst_busy", W'(o_busy), W'(0));
        chk("arst_consume", W'({o_c0, o_c1, o_c2, o_inst_done}), W'(0));
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        clr_tally();
        pr = 1'b1;
        sv = 1'b1; si = mk(8'h07, 1'b1);
        tick();
        sv = 1'b0;
        repeat (4) tick();
        chk("post_rst_dispatch", W'(got.size()), W'(1));
        chk("post_rst_done", W'(n_done), W'(1));

        // Random traffic including enable gaps and occasional flushes.
        for (int i = 0; i < 400; i++) begin
            en  = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 49) == 0);
            sv  = ($urandom_range(0, 3) != 0);
            si  = mk(8'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0));
            a0  = ($urandom_range(0, 3) != 0);
            a1  = ($urandom_range(0, 3) != 0);
            a2  = ($urandom_range(0, 3) != 0);
            pr  = ($urandom_range(0, 9) < 7);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
